// File: rtl/wb_slave_mem.sv
// rtl/wb_slave_mem.sv - Wishbone classic single-port memory slave with wait states and debug counters
//
// Purpose:
//   Terminates Wishbone classic cycles against a DEPTH-word memory mapped at
//   word address BASE_ADDR. In-range accesses end with ack_o and out-of-range
//   accesses end with err_o. Each response is a single-cycle pulse.
//   WAIT_CYCLES inserts extra cycles between accepting a request and responding.
//   Saturating counters report committed writes, completed reads and errors.
//
// Ports:
//   clk_i        in   1           clock, rising edge
//   rst_i        in   1           asynchronous reset, active low
//   cyc_i        in   1           bus cycle valid
//   stb_i        in   1           strobe
//   we_i         in   1           1 = write, 0 = read
//   adr_i        in   ADR_WIDTH   word address
//   dat_i        in   DATA_WIDTH  write data
//   sel_i        in   1           write qualifier (0 = write suppressed but still acked)
//   dat_o        out  DATA_WIDTH  read data, held until the next successful read
//   ack_o        out  1           normal termination pulse
//   err_o        out  1           error termination pulse
//   wr_count_o   out  CNT_WIDTH   committed writes (saturating)
//   rd_count_o   out  CNT_WIDTH   completed reads (saturating)
//   err_count_o  out  CNT_WIDTH   error terminations (saturating)

module wb_slave_mem #(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int BASE_ADDR   = 0,
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADR_WIDTH-1:0]  adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  sel_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  wr_count_o,
    output logic [CNT_WIDTH-1:0]  rd_count_o,
    output logic [CNT_WIDTH-1:0]  err_count_o
);

    localparam int                   IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADR_WIDTH-1:0] BASE_A    = ADR_WIDTH'(BASE_ADDR);
    localparam logic [ADR_WIDTH-1:0] DEPTH_A   = ADR_WIDTH'(DEPTH);
    // The counter is loaded with WAIT_CYCLES-1 because the cycle that sees
    // zero is itself the last wait cycle before the response edge.
    localparam logic [3:0]           WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [3:0]              r_wait_cnt;
    logic                    r_we;
    logic                    r_sel;
    logic                    r_in_range;
    logic [IDX_W-1:0]        r_idx;
    logic [DATA_WIDTH-1:0]   r_dat;
    logic [DATA_WIDTH-1:0]   r_dat_o;
    logic                    r_ack;
    logic                    r_err;
    logic [CNT_WIDTH-1:0]    r_wr_cnt;
    logic [CNT_WIDTH-1:0]    r_rd_cnt;
    logic [CNT_WIDTH-1:0]    r_err_cnt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                    w_req;
    logic                    w_borrow;
    logic [ADR_WIDTH-1:0]    w_idx;
    logic                    w_in_range;
    state_t                  w_next_state;
    logic                    w_accept;
    logic                    w_go_resp;
    logic                    w_cur_we;
    logic                    w_cur_sel;
    logic                    w_cur_in_range;
    logic [IDX_W-1:0]        w_cur_idx;
    logic [DATA_WIDTH-1:0]   w_cur_dat;
    logic                    w_mem_we;

    assign w_req = cyc_i & stb_i;

    // The subtraction is one bit wider so that the borrow flags addresses
    // below BASE_ADDR. Without it they would wrap around and could appear
    // to be in range.
    assign {w_borrow, w_idx} = {1'b0, adr_i} - {1'b0, BASE_A};
    assign w_in_range        = ~w_borrow & (w_idx < DEPTH_A);

    // With zero wait states the response edge is also the accept edge, so
    // the operands come straight from the bus. Otherwise they come from the
    // values latched at accept.
    always_comb begin
        w_cur_we       = r_we;
        w_cur_sel      = r_sel;
        w_cur_in_range = r_in_range;
        w_cur_idx      = r_idx;
        w_cur_dat      = r_dat;
        if (r_state == ST_IDLE) begin
            w_cur_we       = we_i;
            w_cur_sel      = sel_i;
            w_cur_in_range = w_in_range;
            w_cur_idx      = w_idx[IDX_W-1:0];
            w_cur_dat      = dat_i;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_go_resp    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = ST_RESP;
                        w_go_resp    = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Dropping cyc_i abandons the access silently, even on the
                // last wait cycle.
                if (!cyc_i) begin
                    w_next_state = ST_IDLE;
                end else if (r_wait_cnt == 4'd0) begin
                    w_next_state = ST_RESP;
                    w_go_resp    = 1'b1;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // State, response and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_we       <= 1'b0;
            r_sel      <= 1'b0;
            r_in_range <= 1'b0;
            r_idx      <= '0;
            r_dat      <= '0;
            r_dat_o    <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;

            if (w_accept) begin
                r_we       <= we_i;
                r_sel      <= sel_i;
                r_in_range <= w_in_range;
                r_idx      <= w_idx[IDX_W-1:0];
                r_dat      <= dat_i;
                r_wait_cnt <= WAIT_LOAD;
            end else if ((r_state == ST_WAIT) && cyc_i && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            if (w_go_resp) begin
                if (w_cur_in_range) begin
                    r_ack <= 1'b1;
                    if (w_cur_we) begin
                        if (w_cur_sel) begin
                            r_wr_cnt <= sat_inc(r_wr_cnt);
                        end
                    end else begin
                        r_dat_o  <= r_mem[w_cur_idx];
                        r_rd_cnt <= sat_inc(r_rd_cnt);
                    end
                end else begin
                    r_err     <= 1'b1;
                    r_err_cnt <= sat_inc(r_err_cnt);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory array (not reset). The write is qualified by rst_i so that an
    // edge arriving while reset is held cannot commit a zero-wait write.
    // ------------------------------------------------------------------
    assign w_mem_we = rst_i & w_go_resp & w_cur_in_range & w_cur_we & w_cur_sel;

    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[w_cur_idx] <= w_cur_dat;
        end
    end

    assign dat_o       = r_dat_o;
    assign ack_o       = r_ack;
    assign err_o       = r_err;
    assign wr_count_o  = r_wr_cnt;
    assign rd_count_o  = r_rd_cnt;
    assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_wb_slave_mem.sv
// tb/tb_wb_slave_mem.sv - scoreboard bench for wb_slave_mem (zero-wait and three-wait instances)

module tb_wb_slave_mem;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rst_n = 2'b00;
    logic [1:0]    cyc   = 2'b00;
    logic [1:0]    stb   = 2'b00;
    logic [1:0]    we    = 2'b00;
    logic [1:0]    sel   = 2'b00;
    logic [AW-1:0] adr  [2];
    logic [DW-1:0] wdat [2];
    logic [1:0]    ack;
    logic [1:0]    err;
    logic [DW-1:0] rdat0, rdat1;
    logic [15:0]   wr0, rd0, er0;
    logic [2:0]    wr3, rd3, er3;

    // Instance 0: zero wait states, base 0, 16-bit counters.
    wb_slave_mem #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .BASE_ADDR(0),
                   .WAIT_CYCLES(0), .CNT_WIDTH(16)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
        .adr_i(adr[0]), .dat_i(wdat[0]), .sel_i(sel[0]), .dat_o(rdat0),
        .ack_o(ack[0]), .err_o(err[0]),
        .wr_count_o(wr0), .rd_count_o(rd0), .err_count_o(er0));

    // Instance 1: three wait states, base 8, 3-bit counters so saturation is reachable.
    wb_slave_mem #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .BASE_ADDR(8),
                   .WAIT_CYCLES(3), .CNT_WIDTH(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_n[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
        .adr_i(adr[1]), .dat_i(wdat[1]), .sel_i(sel[1]), .dat_o(rdat1),
        .ack_o(ack[1]), .err_o(err[1]),
        .wr_count_o(wr3), .rd_count_o(rd3), .err_count_o(er3));

    typedef struct {
        logic        is_err;
        logic        chk_dat;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_wr[2] = '{0, 0};
    int exp_rd[2] = '{0, 0};
    int exp_er[2] = '{0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    function automatic logic [31:0] rdat_of(input int k);
        return (k == 0) ? rdat0 : rdat1;
    endfunction

    function automatic logic [31:0] wr_of(input int k);
        return (k == 0) ? {16'd0, wr0} : {29'd0, wr3};
    endfunction

    function automatic logic [31:0] rd_of(input int k);
        return (k == 0) ? {16'd0, rd0} : {29'd0, rd3};
    endfunction

    function automatic logic [31:0] er_of(input int k);
        return (k == 0) ? {16'd0, er0} : {29'd0, er3};
    endfunction

    function automatic logic [31:0] sat(input int v, input int k);
        int mx;
        mx = (k == 0) ? 65535 : 7;
        return 32'((v > mx) ? mx : v);
    endfunction

    // Monitor: each response pops one expectation; also checks exclusivity and pulse width.
    logic [1:0] prev_resp = 2'b00;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            int   sz;
            if (ack[k] | err[k]) begin
                sz = (k == 0) ? q0.size() : q1.size();
                chk($sformatf("dut%0d ack/err exclusive and one cycle", k),
                    {30'd0, ack[k] & err[k], prev_resp[k]}, 32'd0);
                if (sz == 0) begin
                    chk($sformatf("dut%0d unexpected response", k), 32'd1, 32'd0);
                end else begin
                    if (k == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("dut%0d response is err", k), {31'd0, err[k]}, {31'd0, e.is_err});
                    if (e.chk_dat) chk($sformatf("dut%0d dat_o", k), rdat_of(k), e.data);
                end
            end
            prev_resp[k] <= ack[k] | err[k];
        end
    end

    task automatic check_cnt(input int k);
        chk($sformatf("dut%0d wr_count", k),  wr_of(k), sat(exp_wr[k], k));
        chk($sformatf("dut%0d rd_count", k),  rd_of(k), sat(exp_rd[k], k));
        chk($sformatf("dut%0d err_count", k), er_of(k), sat(exp_er[k], k));
    endtask

    task automatic check_zero(input int k);
        chk($sformatf("dut%0d reset ack", k), {31'd0, ack[k]}, 32'd0);
        chk($sformatf("dut%0d reset err", k), {31'd0, err[k]}, 32'd0);
        chk($sformatf("dut%0d reset dat_o", k), rdat_of(k), 32'd0);
        chk($sformatf("dut%0d reset wr_count", k), wr_of(k), 32'd0);
        chk($sformatf("dut%0d reset rd_count", k), rd_of(k), 32'd0);
        chk($sformatf("dut%0d reset err_count", k), er_of(k), 32'd0);
    endtask

    // One classic Wishbone access; pushes the expected response and checks latency.
    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic s, input logic exp_err, input logic chk_dat,
                        input logic [31:0] exp_dat);
        exp_t e;
        int   lat;
        e.is_err  = exp_err;
        e.chk_dat = chk_dat;
        e.data    = exp_dat;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        if (exp_err)    exp_er[k]++;
        else if (!w)    exp_rd[k]++;
        else if (s)     exp_wr[k]++;
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; wdat[k] = d; sel[k] = s;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(ack[k] | err[k]) && lat < 40);
        chk($sformatf("dut%0d latency adr 0x%0h", k, a), 32'(lat), (k == 0) ? 32'd1 : 32'd4);
        @(negedge clk);
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
    endtask

    // Directed table for the write-then-readback loop (word offsets within the window).
    logic [3:0]  tbl_off [8] = '{4'd0, 4'd1, 4'd5, 4'd9, 4'd12, 4'd14, 4'd15, 4'd6};
    logic [31:0] tbl_dat [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'h1234_5678,
                                 32'h8000_0000, 32'h0F0F_F0F0, 32'hCAFE_BABE, 32'h0000_0100};

    initial begin
        adr[0] = '0; adr[1] = '0; wdat[0] = '0; wdat[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero(0);
        check_zero(1);
        @(negedge clk);
        rst_n = 2'b11;

        // Zero-wait write then read back.
        xfer(0, 1'b1, 32'd3, 32'h0000_000A, 1'b1, 1'b0, 1'b0, 32'd0);
        xfer(0, 1'b0, 32'd3, 32'd0,         1'b1, 1'b0, 1'b1, 32'h0000_000A);
        check_cnt(0);

        // Out-of-range write errors, dat_o holds; retry in range and read back.
        xfer(0, 1'b1, 32'd16, 32'h0000_1234, 1'b1, 1'b1, 1'b1, 32'h0000_000A);
        xfer(0, 1'b1, 32'd15, 32'h0000_BEEF, 1'b1, 1'b0, 1'b0, 32'd0);
        xfer(0, 1'b0, 32'd15, 32'd0,         1'b1, 1'b0, 1'b1, 32'h0000_BEEF);
        check_cnt(0);

        // Suppressed write (sel=0) is acked but leaves memory and wr_count alone.
        xfer(0, 1'b1, 32'd2, 32'h7, 1'b1, 1'b0, 1'b0, 32'd0);
        xfer(0, 1'b1, 32'd2, 32'h5, 1'b0, 1'b0, 1'b0, 32'd0);
        xfer(0, 1'b0, 32'd2, 32'd0, 1'b1, 1'b0, 1'b1, 32'h7);
        xfer(0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b1, 32'h7);
        check_cnt(0);

        // Three wait states, base 8: latency 4, window edges 7 and 24 error.
        xfer(1, 1'b1, 32'd8,  32'h1111_2222, 1'b1, 1'b0, 1'b0, 32'd0);
        xfer(1, 1'b0, 32'd8,  32'd0,         1'b1, 1'b0, 1'b1, 32'h1111_2222);
        xfer(1, 1'b1, 32'd7,  32'h0000_0099, 1'b1, 1'b1, 1'b0, 32'd0);
        xfer(1, 1'b0, 32'd24, 32'd0,         1'b1, 1'b1, 1'b1, 32'h1111_2222);
        xfer(1, 1'b1, 32'd23, 32'h0000_7777, 1'b1, 1'b0, 1'b0, 32'd0);
        xfer(1, 1'b0, 32'd23, 32'd0,         1'b1, 1'b0, 1'b1, 32'h0000_7777);
        check_cnt(1);

        // Abort a write during WAIT by dropping cyc_i; nothing may change.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'd8; wdat[1] = 32'hBAD0_BAD0; sel[1] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        repeat (6) @(posedge clk);
        check_cnt(1);
        xfer(1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b0, 1'b1, 32'h1111_2222);
        check_cnt(1);

        // Reset during WAIT of a write: outputs clear at once, write dropped.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'd23; wdat[1] = 32'hDEAD_0000; sel[1] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n[1] = 1'b0;
        #1;
        check_zero(1);
        exp_wr[1] = 0; exp_rd[1] = 0; exp_er[1] = 0;
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        xfer(1, 1'b0, 32'd23, 32'd0, 1'b1, 1'b0, 1'b1, 32'h0000_7777);
        check_cnt(1);

        // Write-then-readback traffic on both instances; 3-bit counters saturate at 7.
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b1, {28'd0, tbl_off[i]}, tbl_dat[i], 1'b1, 1'b0, 1'b0, 32'd0);
            xfer(1, 1'b1, 32'd8 + {28'd0, tbl_off[i]}, ~tbl_dat[i], 1'b1, 1'b0, 1'b0, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b0, {28'd0, tbl_off[i]}, 32'd0, 1'b1, 1'b0, 1'b1, tbl_dat[i]);
            xfer(1, 1'b0, 32'd8 + {28'd0, tbl_off[i]}, 32'd0, 1'b1, 1'b0, 1'b1, ~tbl_dat[i]);
        end
        check_cnt(0);
        check_cnt(1);

        repeat (4) @(posedge clk);
        chk("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
        chk("dut1 scoreboard drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
